// File: rtl/gun_position_ctrl.sv
// Joystick-to-light-gun position controller: per-axis acceleration FSMs stepping 6-bit
// gun_h/gun_v on each rising edge of the 4 ms tick.
module gun_position_ctrl #(
  parameter int unsigned POS_MAX     = 63,
  parameter int unsigned CENTER      = 32,
  parameter int unsigned SLOW_DIV    = 4,
  parameter int unsigned ACCEL_STEPS = 8,
  parameter int unsigned FAST_STEP   = 2
) (
  input  logic       clock_12,
  input  logic       reset_n,
  input  logic       tick_4ms,
  input  logic       m_left,
  input  logic       m_right,
  input  logic       m_up,
  input  logic       m_down,
  input  logic       recenter,
  input  logic       freeze,
  output logic [5:0] gun_h,
  output logic [5:0] gun_v,
  output logic       moving,
  output logic [3:0] at_edge
);

  typedef enum logic [1:0] {StIdle, StSlow, StFast} axis_st_e;

  localparam logic [5:0] CenterPos = 6'(CENTER);
  localparam logic [7:0] PosMax8   = 8'(POS_MAX);
  localparam logic [3:0] DivLast   = 4'(SLOW_DIV - 2);
  localparam logic [3:0] AccelCnt  = 4'(ACCEL_STEPS);
  localparam logic [2:0] FastMag   = 3'(FAST_STEP);

  // Index 0 is the horizontal axis, index 1 the vertical axis.
  axis_st_e   state_q [2];
  axis_st_e   state_d [2];
  logic [5:0] pos_q   [2];
  logic [5:0] pos_d   [2];
  logic [3:0] div_q   [2];
  logic [3:0] div_d   [2];
  logic [3:0] steps_q [2];
  logic [3:0] steps_d [2];
  logic       neg_q   [2];
  logic       neg_d   [2];

  logic       tick_d;
  logic       tick_pulse;
  logic [1:0] dir_pos;
  logic [1:0] dir_neg;
  logic       moving_d;
  logic [3:0] at_edge_d;

  assign tick_pulse = tick_4ms & ~tick_d;
  // Opposite directions pressed together cancel to "no direction".
  assign dir_pos    = {m_down & ~m_up, m_right & ~m_left};
  assign dir_neg    = {m_up & ~m_down, m_left & ~m_right};

  function automatic logic [5:0] step_pos(logic [5:0] pos, logic neg, logic [2:0] mag);
    logic [7:0] base;
    logic [7:0] mag8;
    logic [7:0] sum;
    base = {2'b00, pos};
    mag8 = {5'b00000, mag};
    sum  = neg ? (base - mag8) : (base + mag8);
    if (neg && (base < mag8)) begin
      sum = 8'd0;
    end else if (!neg && (sum > PosMax8)) begin
      sum = PosMax8;
    end
    return sum[5:0];
  endfunction

  always_comb begin
    for (int a = 0; a < 2; a++) begin
      state_d[a] = state_q[a];
      pos_d[a]   = pos_q[a];
      div_d[a]   = div_q[a];
      steps_d[a] = steps_q[a];
      neg_d[a]   = neg_q[a];
      if (recenter) begin
        state_d[a] = StIdle;
        pos_d[a]   = CenterPos;
        div_d[a]   = 4'd0;
        steps_d[a] = 4'd0;
        neg_d[a]   = 1'b0;
      end else if (tick_pulse && !freeze) begin
        if (!(dir_pos[a] || dir_neg[a])) begin
          state_d[a] = StIdle;
          div_d[a]   = 4'd0;
          steps_d[a] = 4'd0;
        end else if ((state_q[a] == StIdle) || (dir_neg[a] != neg_q[a])) begin
          // Fresh press or reversal: one fine step, then restart the slow phase.
          state_d[a] = StSlow;
          pos_d[a]   = step_pos(pos_q[a], dir_neg[a], 3'd1);
          div_d[a]   = 4'd0;
          steps_d[a] = 4'd1;
          neg_d[a]   = dir_neg[a];
        end else begin
          unique case (state_q[a])
            StSlow: begin
              if (div_q[a] >= DivLast) begin
                pos_d[a]   = step_pos(pos_q[a], neg_q[a], 3'd1);
                div_d[a]   = 4'd0;
                steps_d[a] = (steps_q[a] == 4'hf) ? steps_q[a] : steps_q[a] + 4'd1;
                // ACCEL_STEPS repeat steps after the initial tap switch to fast mode.
                if (steps_q[a] >= AccelCnt) begin
                  state_d[a] = StFast;
                end
              end else begin
                div_d[a] = div_q[a] + 4'd1;
              end
            end
            StFast: begin
              pos_d[a] = step_pos(pos_q[a], neg_q[a], FastMag);
            end
            default: begin
              state_d[a] = StIdle;
            end
          endcase
        end
      end
    end
    moving_d  = (state_d[0] != StIdle) || (state_d[1] != StIdle);
    at_edge_d = {pos_d[0] == 6'd0, {2'b00, pos_d[0]} == PosMax8,
                 pos_d[1] == 6'd0, {2'b00, pos_d[1]} == PosMax8};
  end

  always_ff @(posedge clock_12 or negedge reset_n) begin
    if (!reset_n) begin
      tick_d  <= 1'b0;
      moving  <= 1'b0;
      at_edge <= 4'd0;
      for (int a = 0; a < 2; a++) begin
        state_q[a] <= StIdle;
        pos_q[a]   <= CenterPos;
        div_q[a]   <= 4'd0;
        steps_q[a] <= 4'd0;
        neg_q[a]   <= 1'b0;
      end
    end else begin
      tick_d  <= tick_4ms;
      moving  <= moving_d;
      at_edge <= at_edge_d;
      for (int a = 0; a < 2; a++) begin
        state_q[a] <= state_d[a];
        pos_q[a]   <= pos_d[a];
        div_q[a]   <= div_d[a];
        steps_q[a] <= steps_d[a];
        neg_q[a]   <= neg_d[a];
      end
    end
  end

  assign gun_h = pos_q[0];
  assign gun_v = pos_q[1];

endmodule

// File: tb/tb_gun_position_ctrl.sv
// Directed bench for gun_position_ctrl with hand-computed expected positions.
module tb_gun_position_ctrl;

  logic       clock_12 = 1'b0;
  logic       reset_n  = 1'b0;
  logic       tick_4ms = 1'b0;
  logic       m_left   = 1'b0;
  logic       m_right  = 1'b0;
  logic       m_up     = 1'b0;
  logic       m_down   = 1'b0;
  logic       recenter = 1'b0;
  logic       freeze   = 1'b0;
  logic [5:0] gun_h;
  logic [5:0] gun_v;
  logic       moving;
  logic [3:0] at_edge;

  int n_cmp = 0;
  int n_bad = 0;

  gun_position_ctrl dut (
    .clock_12 (clock_12),
    .reset_n  (reset_n),
    .tick_4ms (tick_4ms),
    .m_left   (m_left),
    .m_right  (m_right),
    .m_up     (m_up),
    .m_down   (m_down),
    .recenter (recenter),
    .freeze   (freeze),
    .gun_h    (gun_h),
    .gun_v    (gun_v),
    .moving   (moving),
    .at_edge  (at_edge)
  );

  always #42 clock_12 = ~clock_12;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One 4 ms tick: rising edge lands on the next posedge, then low for two clocks.
  task automatic do_tick();
    @(negedge clock_12);
    tick_4ms = 1'b1;
    @(negedge clock_12);
    tick_4ms = 1'b0;
    @(negedge clock_12);
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  initial begin
    #100;
    check_eq("reset_gun_h", gun_h, 32);
    check_eq("reset_gun_v", gun_v, 32);
    check_eq("reset_moving", moving, 0);
    check_eq("reset_at_edge", at_edge, 0);
    @(negedge clock_12);
    reset_n = 1'b1;

    // Single tap then release.
    m_right = 1'b1;
    @(negedge clock_12);
    tick_4ms = 1'b1;
    @(posedge clock_12);
    #1;
    check_eq("tap_gun_h_one_clock", gun_h, 33);
    check_eq("tap_moving", moving, 1);
    @(negedge clock_12);
    tick_4ms = 1'b0;
    @(negedge clock_12);
    m_right = 1'b0;
    do_tick();
    check_eq("release_gun_h", gun_h, 33);
    check_eq("release_moving", moving, 0);

    // Acceleration from 33: FAST reached on tick 25 at 33 + 1 + 8 = 42.
    m_right = 1'b1;
    do_ticks(24);
    check_eq("slow_tick24", gun_h, 41);
    do_tick();
    check_eq("fast_entry", gun_h, 42);
    for (int k = 1; k <= 4; k++) begin
      do_tick();
      check_eq("fast_step", gun_h, 42 + 2 * k);
    end

    // FAST at 50: recenter in the same cycle as the tick pulse.
    @(negedge clock_12);
    tick_4ms = 1'b1;
    recenter = 1'b1;
    @(negedge clock_12);
    tick_4ms = 1'b0;
    recenter = 1'b0;
    m_right  = 1'b0;
    @(negedge clock_12);
    check_eq("recenter_gun_h", gun_h, 32);
    check_eq("recenter_gun_v", gun_v, 32);
    check_eq("recenter_moving", moving, 0);

    // Reach FAST again, then reverse: one step down and back in SLOW.
    m_right = 1'b1;
    do_ticks(25);
    check_eq("fast_again", gun_h, 41);
    do_tick();
    check_eq("fast_again_step", gun_h, 43);
    m_right = 1'b0;
    m_left  = 1'b1;
    do_tick();
    check_eq("reversal_step", gun_h, 42);
    do_ticks(2);
    check_eq("reversal_slow_hold", gun_h, 42);
    do_tick();
    check_eq("reversal_slow_step", gun_h, 41);
    m_right = 1'b1;
    do_tick();
    check_eq("both_pressed_gun_h", gun_h, 41);
    check_eq("both_pressed_moving", moving, 0);
    m_right = 1'b0;
    m_left  = 1'b0;

    // Freeze with m_down held: nothing moves, and release while tick is high is not a tick.
    freeze = 1'b1;
    m_down = 1'b1;
    do_ticks(10);
    check_eq("freeze_gun_v", gun_v, 32);
    check_eq("freeze_moving", moving, 0);
    @(negedge clock_12);
    tick_4ms = 1'b1;
    repeat (2) @(negedge clock_12);
    freeze = 1'b0;
    repeat (3) @(negedge clock_12);
    check_eq("unfreeze_no_spurious", gun_v, 32);
    tick_4ms = 1'b0;
    @(negedge clock_12);
    do_tick();
    check_eq("unfreeze_first_step", gun_v, 33);
    m_down = 1'b0;
    do_tick();
    check_eq("v_release_moving", moving, 0);

    // Left from 41 to the lower clamp: 40, SLOW to 32 at tick 25, then -2 per tick.
    m_left = 1'b1;
    do_ticks(25);
    check_eq("left_fast_entry", gun_h, 32);
    do_ticks(15);
    check_eq("left_near_min", gun_h, 2);
    do_tick();
    check_eq("left_at_min", gun_h, 0);
    check_eq("left_h_min_flag", at_edge, 4'b1000);
    do_ticks(3);
    check_eq("left_hold_min", gun_h, 0);

    // Reverse to the right from 0: 1, 9 at FAST entry, then +2 to the upper clamp.
    m_left  = 1'b0;
    m_right = 1'b1;
    do_ticks(25);
    check_eq("right_fast_entry", gun_h, 9);
    do_ticks(26);
    check_eq("right_near_max", gun_h, 61);
    do_tick();
    check_eq("right_at_max", gun_h, 63);
    check_eq("right_h_max_flag", at_edge, 4'b0100);
    do_tick();
    check_eq("right_hold_max", gun_h, 63);

    // Asynchronous reset between edges during FAST.
    @(posedge clock_12);
    #10;
    reset_n = 1'b0;
    #1;
    check_eq("async_reset_gun_h", gun_h, 32);
    check_eq("async_reset_gun_v", gun_v, 32);
    check_eq("async_reset_moving", moving, 0);
    @(negedge clock_12);
    reset_n = 1'b1;
    do_tick();
    check_eq("restart_idle_step", gun_h, 33);
    do_tick();
    check_eq("restart_slow_hold", gun_h, 33);
    m_right = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
